// File: rtl/axi_pkg.sv
// axi_pkg: AXI constants, shared widths and the master FSM state type.
// Used by axi_req_master. The SRAM_wrapper slave uses the same widths.
package axi_pkg;

  // Widths shared with the SRAM_wrapper slave
  localparam int AXI_ID_WIDTH   = 4;
  localparam int AXI_LEN_WIDTH  = 4;
  localparam int AXI_ADDR_WIDTH = 16;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_AW,
    ST_W,
    ST_B
  } mst_state_e;

  // Worst-of-two response. The numeric order already ranks the codes:
  // DECERR > SLVERR > EXOKAY > OKAY.
  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi_beat_cnt.sv
// axi_beat_cnt: burst beat counter with a last-beat compare.
// Ports: clk, rst (sync, active-high), clr (restart at beat 0),
//        inc (count one accepted beat), len (beats-1), last (beat == len).
module axi_beat_cnt #(
  parameter int LEN_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 inc,
  input  logic [LEN_WIDTH-1:0] len,
  output logic                 last
);

  logic [LEN_WIDTH-1:0] beat_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      beat_reg <= '0;
    end else if (inc) begin
      beat_reg <= beat_reg + 1'b1;
    end
  end

  assign last = (beat_reg == len);

endmodule

// File: rtl/axi_req_master.sv
// axi_req_master: converts native request and stream interfaces into
// single-outstanding AXI4 INCR bursts (AR->R for reads, AW->W->B for writes).
// Ports:
//   req_*   : command handshake (write flag, byte address, beats-1, id)
//   wdat_*  : write beat stream, passed through to W without buffering
//   rsp_*   : read beat stream, passed through from R without buffering
//   done_o  : one-cycle completion pulse; done_resp_o holds the worst response
//   proto_err_o : sticky, set on ID mismatch or a misplaced RLAST
//   aw*/w*/b*/ar*/r* : AXI4 master channels
module axi_req_master
  import axi_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = AXI_ADDR_WIDTH,
  parameter int ID_WIDTH   = AXI_ID_WIDTH,
  parameter int LEN_WIDTH  = AXI_LEN_WIDTH,
  parameter int MAXLEN     = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_write_i,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [LEN_WIDTH-1:0]    req_len_i,
  input  logic [ID_WIDTH-1:0]     req_id_i,
  input  logic                    wdat_valid_i,
  output logic                    wdat_ready_o,
  input  logic [DATA_WIDTH-1:0]   wdat_i,
  input  logic [DATA_WIDTH/8-1:0] wstrb_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_data_o,
  output logic                    rsp_last_o,
  output logic                    done_o,
  output logic [1:0]              done_resp_o,
  output logic                    proto_err_o,
  output logic [ID_WIDTH-1:0]     awid_o,
  output logic [ADDR_WIDTH-1:0]   awaddr_o,
  output logic [LEN_WIDTH-1:0]    awlen_o,
  output logic [2:0]              awsize_o,
  output logic [1:0]              awburst_o,
  output logic                    awvalid_o,
  input  logic                    awready_i,
  output logic [DATA_WIDTH-1:0]   wdata_o,
  output logic [DATA_WIDTH/8-1:0] wstrb_o,
  output logic                    wlast_o,
  output logic                    wvalid_o,
  input  logic                    wready_i,
  input  logic [ID_WIDTH-1:0]     bid_i,
  input  logic [1:0]              bresp_i,
  input  logic                    bvalid_i,
  output logic                    bready_o,
  output logic [ID_WIDTH-1:0]     arid_o,
  output logic [ADDR_WIDTH-1:0]   araddr_o,
  output logic [LEN_WIDTH-1:0]    arlen_o,
  output logic [2:0]              arsize_o,
  output logic [1:0]              arburst_o,
  output logic                    arvalid_o,
  input  logic                    arready_i,
  input  logic [ID_WIDTH-1:0]     rid_i,
  input  logic [DATA_WIDTH-1:0]   rdata_i,
  input  logic [1:0]              rresp_i,
  input  logic                    rlast_i,
  input  logic                    rvalid_i,
  output logic                    rready_o
);

  localparam logic [2:0]           AXSIZE   = 3'($clog2(DATA_WIDTH/8));
  localparam logic [LEN_WIDTH-1:0] MAXLEN_L = LEN_WIDTH'(MAXLEN);

  mst_state_e            state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [ID_WIDTH-1:0]   id_reg;
  logic [LEN_WIDTH-1:0]  len_reg;
  logic [1:0]            resp_reg, resp_next;
  logic                  done_reg, done_next;
  logic                  err_reg, err_next;
  logic                  latch;
  logic                  cnt_clr;
  logic                  cnt_inc;
  logic                  beat_last;
  logic                  idle_ready;
  logic [LEN_WIDTH-1:0]  len_clamped;

  assign len_clamped = (req_len_i > MAXLEN_L) ? MAXLEN_L : req_len_i;

  axi_beat_cnt #(.LEN_WIDTH(LEN_WIDTH)) u_beat_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .len  (len_reg),
    .last (beat_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      addr_reg  <= '0;
      id_reg    <= '0;
      len_reg   <= '0;
      resp_reg  <= AXI_RESP_OKAY;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      resp_reg  <= resp_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
      if (latch) begin
        addr_reg <= req_addr_i;
        id_reg   <= req_id_i;
        len_reg  <= len_clamped;
      end
    end
  end

  // Holding off for the done cycle keeps the completion pulse and the next
  // accept in separate cycles.
  assign idle_ready  = (state_reg == ST_IDLE) && !done_reg;
  assign req_ready_o = idle_ready && !rst;

  always_comb begin
    state_next   = state_reg;
    resp_next    = resp_reg;
    done_next    = 1'b0;
    err_next     = err_reg;
    latch        = 1'b0;
    cnt_clr      = 1'b0;
    cnt_inc      = 1'b0;
    awvalid_o    = 1'b0;
    awsize_o     = 3'd0;
    awburst_o    = 2'b00;
    arvalid_o    = 1'b0;
    arsize_o     = 3'd0;
    arburst_o    = 2'b00;
    wvalid_o     = 1'b0;
    wdat_ready_o = 1'b0;
    wlast_o      = 1'b0;
    wdata_o      = '0;
    wstrb_o      = '0;
    bready_o     = 1'b0;
    rready_o     = 1'b0;
    rsp_valid_o  = 1'b0;
    rsp_data_o   = '0;
    rsp_last_o   = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (req_valid_i && idle_ready) begin
          latch      = 1'b1;
          cnt_clr    = 1'b1;
          resp_next  = AXI_RESP_OKAY;
          state_next = req_write_i ? ST_AW : ST_AR;
        end
      end
      ST_AR: begin
        arvalid_o = 1'b1;
        arsize_o  = AXSIZE;
        arburst_o = AXI_BURST_INCR;
        if (arready_i) state_next = ST_R;
      end
      ST_R: begin
        rready_o    = rsp_ready_i;
        rsp_valid_o = rvalid_i;
        rsp_data_o  = rdata_i;
        rsp_last_o  = rlast_i;
        if (rvalid_i && rsp_ready_i) begin
          cnt_inc   = 1'b1;
          resp_next = resp_max(resp_reg, rresp_i);
          // RLAST must coincide exactly with the final counted beat;
          // the burst still terminates on the slave's RLAST either way.
          if ((rid_i != id_reg) || (rlast_i != beat_last)) err_next = 1'b1;
          if (rlast_i) begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
          end
        end
      end
      ST_AW: begin
        awvalid_o = 1'b1;
        awsize_o  = AXSIZE;
        awburst_o = AXI_BURST_INCR;
        if (awready_i) state_next = ST_W;
      end
      ST_W: begin
        wvalid_o     = wdat_valid_i;
        wdat_ready_o = wready_i;
        wlast_o      = beat_last;
        wdata_o      = wdat_i;
        wstrb_o      = wstrb_i;
        if (wdat_valid_i && wready_i) begin
          cnt_inc = 1'b1;
          if (beat_last) state_next = ST_B;
        end
      end
      ST_B: begin
        bready_o = 1'b1;
        if (bvalid_i) begin
          resp_next  = resp_max(resp_reg, bresp_i);
          if (bid_i != id_reg) err_next = 1'b1;
          done_next  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign awid_o      = id_reg;
  assign awaddr_o    = addr_reg;
  assign awlen_o     = len_reg;
  assign arid_o      = id_reg;
  assign araddr_o    = addr_reg;
  assign arlen_o     = len_reg;
  assign done_o      = done_reg;
  assign done_resp_o = resp_reg;
  assign proto_err_o = err_reg;

endmodule

// File: tb/tb_axi_req_master.sv
// Directed bench for axi_req_master with a small reactive AXI slave model.
module tb_axi_req_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [15:0] req_addr = '0;
  logic [3:0]  req_len = '0;
  logic [3:0]  req_id = '0;
  logic        wdat_valid = 1'b0;
  logic        wdat_ready;
  logic [31:0] wdat = '0;
  logic [3:0]  wstrb = 4'hF;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_last;
  logic        done;
  logic [1:0]  done_resp;
  logic        proto_err;
  logic [3:0]  awid;
  logic [15:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb_o;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  arid;
  logic [15:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  always #5 clk = ~clk;

  axi_req_master dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_len_i(req_len), .req_id_i(req_id),
    .wdat_valid_i(wdat_valid), .wdat_ready_o(wdat_ready), .wdat_i(wdat), .wstrb_i(wstrb),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data), .rsp_last_o(rsp_last),
    .done_o(done), .done_resp_o(done_resp), .proto_err_o(proto_err),
    .awid_o(awid), .awaddr_o(awaddr), .awlen_o(awlen), .awsize_o(awsize), .awburst_o(awburst),
    .awvalid_o(awvalid), .awready_i(awready),
    .wdata_o(wdata), .wstrb_o(wstrb_o), .wlast_o(wlast), .wvalid_o(wvalid), .wready_i(wready),
    .bid_i(bid), .bresp_i(bresp), .bvalid_i(bvalid), .bready_o(bready),
    .arid_o(arid), .araddr_o(araddr), .arlen_o(arlen), .arsize_o(arsize), .arburst_o(arburst),
    .arvalid_o(arvalid), .arready_i(arready),
    .rid_i(rid), .rdata_i(rdata), .rresp_i(rresp), .rlast_i(rlast), .rvalid_i(rvalid), .rready_o(rready)
  );

  // ---------------- slave model configuration and state ----------------
  int          ar_delay  = 0;
  logic [3:0]  rid_xor   = '0;
  logic [3:0]  bid_xor   = '0;
  logic [1:0]  rresp_cfg = '0;
  logic [1:0]  bresp_cfg = '0;
  int          w_early   = 0;
  logic [31:0] mem [256];
  int          ar_cnt, rd_idx, rd_len, rd_beat, wr_idx, wr_beat;
  logic        rd_busy, wr_busy;
  logic [3:0]  wr_id;

  always @(posedge clk) begin
    if (rst) begin
      arready <= 1'b0; ar_cnt <= 0; rd_busy <= 1'b0; rvalid <= 1'b0; rlast <= 1'b0;
      rdata <= '0; rid <= '0; rresp <= '0; rd_idx <= 0; rd_len <= 0; rd_beat <= 0;
      awready <= 1'b0; wready <= 1'b0; wr_busy <= 1'b0; bvalid <= 1'b0;
      bid <= '0; bresp <= '0; wr_idx <= 0; wr_beat <= 0; wr_id <= '0;
      for (int i = 0; i < 256; i++) mem[i] <= 32'h1000 + i;
    end else begin
      if (arvalid && !arready && !rd_busy) begin
        if (ar_cnt >= ar_delay) begin arready <= 1'b1; ar_cnt <= 0; end
        else ar_cnt <= ar_cnt + 1;
      end
      if (arvalid && arready) begin
        arready <= 1'b0; rd_busy <= 1'b1;
        rd_idx <= int'(araddr[9:2]); rd_len <= int'(arlen); rd_beat <= 0;
        rvalid <= 1'b1; rdata <= mem[araddr[9:2]]; rlast <= (arlen == 4'd0);
        rid <= arid ^ rid_xor; rresp <= rresp_cfg;
      end
      if (rvalid && rready) begin
        if (rlast) begin
          rvalid <= 1'b0; rlast <= 1'b0; rd_busy <= 1'b0;
        end else begin
          rd_beat <= rd_beat + 1;
          rdata   <= mem[(rd_idx + rd_beat + 1) & 255];
          rlast   <= (rd_beat + 1 == rd_len);
        end
      end
      if (awvalid && !awready && !wr_busy) awready <= 1'b1;
      if (awvalid && awready) begin
        awready <= 1'b0; wr_busy <= 1'b1; wr_idx <= int'(awaddr[9:2]);
        wr_id <= awid; wr_beat <= 0; wready <= 1'b1;
      end
      if (wvalid && !wr_busy) w_early <= w_early + 1;
      if (wvalid && wready) begin
        mem[(wr_idx + wr_beat) & 255] <= wdata;
        wr_beat <= wr_beat + 1;
        if (wlast) begin
          wready <= 1'b0; bvalid <= 1'b1; bid <= wr_id ^ bid_xor; bresp <= bresp_cfg;
        end
      end
      if (bvalid && bready) begin bvalid <= 1'b0; wr_busy <= 1'b0; end
    end
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] got_data [$];
  logic        got_last [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic wr, input logic [15:0] a, input logic [3:0] l, input logic [3:0] id);
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_len = l; req_id = id;
    #1;
    while (!req_ready && n < 50) begin @(negedge clk); #1; n++; end
    check("req_accepted", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    $display("req  wr=%0d addr=0x%04h len=%0d id=%0d", wr, a, l, id);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    @(negedge clk); #1;
    while (!done && n < 30) begin @(negedge clk); #1; n++; end
    check(tag, {31'd0, done}, 32'd1);
    $display("done resp=%0d proto_err=%0d", done_resp, proto_err);
  endtask

  // Collects one read burst; pat gives rsp_ready per cycle (bit i%4).
  task automatic collect(input logic [3:0] pat, input bit chk_mirror);
    int cyc = 0;
    bit fin = 0;
    got_data.delete(); got_last.delete();
    while (!fin && cyc < 100) begin
      @(negedge clk);
      rsp_ready = pat[cyc % 4];
      #1;
      if (chk_mirror && rsp_valid) check("rready_mirror", {31'd0, rready}, {31'd0, rsp_ready});
      if (rsp_valid && rsp_ready) begin
        got_data.push_back(rsp_data); got_last.push_back(rsp_last);
        $display("rbeat data=0x%08h last=%0d", rsp_data, rsp_last);
        if (rsp_last) fin = 1;
      end
      cyc++;
    end
    check("rd_last_seen", {31'd0, fin}, 32'd1);
    wait_done("rd_done");
    rsp_ready = 1'b0;
  endtask

  task automatic write_beats(input int nb, input int len, input logic [31:0] d0);
    int k = 0;
    int cyc = 0;
    while (k < nb && cyc < 100) begin
      @(negedge clk);
      wdat_valid = 1'b1; wdat = d0 + k; wstrb = 4'hF;
      #1;
      if (wvalid && wdat_ready) begin
        check("wlast", {31'd0, wlast}, {31'd0, (k == len)});
        check("wstrb", {28'd0, wstrb_o}, 32'hF);
        $display("wbeat %0d data=0x%08h last=%0d", k, wdata, wlast);
        k++;
      end
      cyc++;
    end
    check("w_beats", k, nb);
    @(negedge clk);
    wdat_valid = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    rst = 1'b0;
    @(negedge clk); #1;
    check("idle_req_ready", {31'd0, req_ready}, 32'd1);
    check("idle_done", {31'd0, done}, 32'd0);
    check("idle_err", {31'd0, proto_err}, 32'd0);
    check("idle_arvalid", {31'd0, arvalid}, 32'd0);

    // Read len 0 with arready held off
    ar_delay = 2;
    issue(1'b0, 16'h0010, 4'd0, 4'd3);
    @(negedge clk); #1;
    check("ar_valid", {31'd0, arvalid}, 32'd1);
    check("ar_addr", {16'd0, araddr}, 32'h0010);
    check("ar_len", {28'd0, arlen}, 32'd0);
    check("ar_size", {29'd0, arsize}, 32'd2);
    check("ar_burst", {30'd0, arburst}, 32'd1);
    check("ar_id", {28'd0, arid}, 32'd3);
    repeat (2) @(negedge clk);
    #1;
    check("ar_held_valid", {31'd0, arvalid}, 32'd1);
    check("ar_held_addr", {16'd0, araddr}, 32'h0010);
    collect(4'hF, 1'b0);
    check("rd0_beats", got_data.size(), 1);
    check("rd0_data", got_data[0], 32'h1004);
    check("rd0_last", {31'd0, got_last[0]}, 32'd1);
    check("rd0_resp", {30'd0, done_resp}, 32'd0);
    @(negedge clk); #1;
    check("done_one_cycle", {31'd0, done}, 32'd0);
    ar_delay = 0;

    // Write len 2, then read it back twice (second time with toggling ready)
    issue(1'b1, 16'h0100, 4'd2, 4'd5);
    wdat_valid = 1'b1; wdat = 32'hDEAD;
    @(negedge clk); #1;
    check("aw_valid", {31'd0, awvalid}, 32'd1);
    check("aw_addr", {16'd0, awaddr}, 32'h0100);
    check("aw_len", {28'd0, awlen}, 32'd2);
    check("aw_size", {29'd0, awsize}, 32'd2);
    check("aw_burst", {30'd0, awburst}, 32'd1);
    check("w_before_aw", {31'd0, wvalid}, 32'd0);
    write_beats(3, 2, 32'hA0);
    wait_done("wr_done");
    check("wr_resp", {30'd0, done_resp}, 32'd0);
    check("wr_err", {31'd0, proto_err}, 32'd0);
    check("w_early", w_early, 0);

    issue(1'b0, 16'h0100, 4'd2, 4'd5);
    collect(4'hF, 1'b0);
    check("rb_beats", got_data.size(), 3);
    for (int i = 0; i < got_data.size(); i++) begin
      check("rb_data", got_data[i], 32'hA0 + i);
      check("rb_last", {31'd0, got_last[i]}, {31'd0, (i == 2)});
    end

    issue(1'b0, 16'h0100, 4'd2, 4'd7);
    collect(4'b0101, 1'b1);
    check("tog_beats", got_data.size(), 3);
    for (int i = 0; i < got_data.size(); i++) check("tog_data", got_data[i], 32'hA0 + i);

    // SLVERR on B
    bresp_cfg = 2'b10;
    issue(1'b1, 16'h0200, 4'd0, 4'd1);
    write_beats(1, 0, 32'hB0);
    wait_done("slverr_done");
    check("slverr_resp", {30'd0, done_resp}, 32'd2);
    check("slverr_err", {31'd0, proto_err}, 32'd0);
    bresp_cfg = 2'b00;

    // Wrong RID sets the sticky error
    rid_xor = 4'h1;
    issue(1'b0, 16'h0000, 4'd0, 4'd6);
    collect(4'hF, 1'b0);
    check("rid_err", {31'd0, proto_err}, 32'd1);
    check("rid_resp", {30'd0, done_resp}, 32'd0);
    rid_xor = 4'h0;

    // Length clamp: req_len 7 -> 3 beats
    issue(1'b0, 16'h0000, 4'd7, 4'd2);
    @(negedge clk); #1;
    check("clamp_arlen", {28'd0, arlen}, 32'd2);
    collect(4'hF, 1'b0);
    check("clamp_beats", got_data.size(), 3);
    for (int i = 0; i < got_data.size(); i++) begin
      check("clamp_data", got_data[i], 32'h1000 + i);
      check("clamp_last", {31'd0, got_last[i]}, {31'd0, (i == 2)});
    end
    check("err_sticky", {31'd0, proto_err}, 32'd1);

    // Reset while W beat 1 is presented
    issue(1'b1, 16'h0300, 4'd2, 4'd9);
    write_beats(1, 2, 32'hC0);
    wdat_valid = 1'b1; wdat = 32'hC1; rst = 1'b1;
    @(negedge clk); #1;
    check("rst_awvalid", {31'd0, awvalid}, 32'd0);
    check("rst_wvalid", {31'd0, wvalid}, 32'd0);
    check("rst_arvalid", {31'd0, arvalid}, 32'd0);
    check("rst_bready", {31'd0, bready}, 32'd0);
    check("rst_wdat_ready", {31'd0, wdat_ready}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, proto_err}, 32'd0);
    check("rst_awaddr", {16'd0, awaddr}, 32'd0);
    rst = 1'b0;
    @(negedge clk); #1;
    check("post_rst_ready", {31'd0, req_ready}, 32'd1);
    check("post_rst_wvalid", {31'd0, wvalid}, 32'd0);
    wdat_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
